// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite types and helpers for the SRAM slave responder.
// Holds bus encodings, slave FSM states and the byte-strobe function.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

    function automatic logic [3:0] strobe(
        input logic [2:0] size,
        input logic [1:0] addr_lo
    );
        logic [3:0] s;
        case (size)
            3'd0:    s = 4'b0001 << addr_lo;
            3'd1:    s = 4'b0011 << addr_lo;
            3'd2:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_array.sv
// Word-organised SRAM with per-byte write enables and an async read port.
// Contents are deliberately left unreset.
module ahb_sram_array #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting an on-chip SRAM, with optional wait states
// and a two-cycle ERROR response for out-of-range or illegal transfers.
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                MEM_WORDS   = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h2000_0000,
    parameter int                WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hrst_b,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int AW = $clog2(MEM_WORDS);

    slv_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        hreadyout_q, hresp_q;
    logic [31:0] hrdata_q, hrdata_d;

    logic        capture, legal, in_range, rd_phase, err_phase;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        unused_in;

    assign unused_in = ^{hburst, hprot, htrans[0]};

    // Base is aligned to the array size, so range is a tag compare.
    assign in_range = haddr[ADDR_W-1:AW+2] == BASE_ADDR[ADDR_W-1:AW+2];
    assign capture  = hsel & hready & htrans[1] & hreadyout_q;

    always_comb begin
        legal = in_range;
        case (hsize)
            HSIZE_BYTE: ;
            HSIZE_HALF: if (haddr[0]) legal = 1'b0;
            HSIZE_WORD: if (haddr[1:0] != 2'b00) legal = 1'b0;
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        size_d  = size_q;
        write_d = write_q;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            addr_d  = haddr[AW+1:2];
            lo_d    = haddr[1:0];
            size_d  = hsize;
            write_d = hwrite;
            if (!legal) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = 3'(WAIT_STATES - 1);
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    assign rd_phase  = (state_q == ST_DATA) && !write_q;
    assign err_phase = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign hrdata_d  = rd_phase ? mem_rdata : hrdata_q;

    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            lo_q        <= 2'd0;
            size_q      <= 3'd0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            write_q     <= write_d;
            hreadyout_q <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
            hresp_q     <= ((state_d == ST_ERR1) || (state_d == ST_ERR2))
                           ? HRESP_ERROR : HRESP_OKAY;
            hrdata_q    <= hrdata_d;
        end
    end

    // Writes land only in the final OKAY data cycle; errors never write.
    assign mem_we = ((state_q == ST_DATA) && write_q) ? strobe(size_q, lo_q) : 4'b0000;

    ahb_sram_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_array (
        .clk   (hclk),
        .waddr (addr_q),
        .we    (mem_we),
        .wdata (hwdata[31:0]),
        .raddr (addr_q),
        .rdata (mem_rdata)
    );

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = err_phase ? '0 : (rd_phase ? mem_rdata : hrdata_q);

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomized and directed bench for the AHB-Lite SRAM slave, two instances
// (zero and three wait states) checked against a byte-level memory model.
module tb_ahb_lite_sram_slave;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        hclk = 1'b0;
    logic        hrst_b = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = '0;
    int          tsel = 0;

    logic        rdy0, rdy3, resp0, resp3;
    logic [31:0] rd0, rd3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;

    op_t q[$];
    bit [7:0] mem_m [bit [32:0]];
    logic [31:0] last_rd;

    always #5 hclk = ~hclk;

    ahb_lite_sram_slave #(.WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hrst_b(hrst_b), .hsel(hsel && tsel == 0),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(3'd0), .hprot(4'd0), .hwdata(hwdata), .hready(rdy0),
        .hreadyout(rdy0), .hresp(resp0), .hrdata(rd0)
    );

    ahb_lite_sram_slave #(.WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hrst_b(hrst_b), .hsel(hsel && tsel == 3),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(3'd1), .hprot(4'd3), .hwdata(hwdata), .hready(rdy3),
        .hreadyout(rdy3), .hresp(resp3), .hrdata(rd3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_m(input logic [31:0] a, input logic [2:0] sz);
        if (a < BASE || a > BASE + 32'h0FFF) return 1'b0;
        if (sz > 3'd2) return 1'b0;
        return (a & ((32'd1 << sz) - 32'd1)) == 32'd0;
    endfunction

    function automatic logic [32:0] key(input int s, input logic [31:0] a);
        return {(s == 3), a};
    endfunction

    function automatic logic [31:0] read_m(input int s, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] wa;
        wa = a & ~32'd3;
        for (int k = 0; k < 4; k++) begin
            if (mem_m.exists(key(s, wa + k))) w[8*k +: 8] = mem_m[key(s, wa + k)];
            else w[8*k +: 8] = 8'hxx;
        end
        return w;
    endfunction

    task automatic write_m(input int s, input op_t o);
        int n;
        n = 1 << o.size;
        for (int k = 0; k < n; k++) begin
            mem_m[key(s, o.addr + k)] = o.wdata[8*((o.addr + k) % 4) +: 8];
        end
    endtask

    function automatic logic sel_rdy(input int s);
        return (s == 0) ? rdy0 : rdy3;
    endfunction

    function automatic logic sel_resp(input int s);
        return (s == 0) ? resp0 : resp3;
    endfunction

    function automatic logic [31:0] sel_rd(input int s);
        return (s == 0) ? rd0 : rd3;
    endfunction

    task automatic push(input logic [1:0] t, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] d);
        op_t o;
        o.trans = t; o.addr = a; o.wr = w; o.size = sz; o.wdata = d;
        q.push_back(o);
    endtask

    // Pipelined master: drives the next address phase while the pending
    // transfer is in its data phase. Called just after a rising edge.
    task automatic run_ops(input int s);
        int   pk;
        int   waits;
        int   ws;
        op_t  pend;
        logic rdy;
        logic perr;
        pk = 0; waits = 0; perr = 1'b0;
        ws = (s == 0) ? 0 : 3;
        tsel = s;
        while (q.size() > 0 || pk != 0) begin
            if (q.size() > 0) begin
                hsel = 1'b1; htrans = q[0].trans; haddr = q[0].addr;
                hwrite = q[0].wr; hsize = q[0].size;
            end else begin
                hsel = 1'b0; htrans = 2'd0;
            end
            if (pk == 2 && pend.wr) hwdata = pend.wdata;
            @(negedge hclk);
            rdy = sel_rdy(s);
            if (pk == 2) begin
                if (!rdy) begin
                    waits++;
                    chk("stall_resp", {31'd0, sel_resp(s)}, {31'd0, perr});
                    if (perr) chk("err1_rdata", sel_rd(s), 32'd0);
                    if (waits > 10) begin
                        chk("stall_timeout", 32'(waits), 32'(ws));
                        q.delete(); pk = 0;
                    end
                end else begin
                    chk("wait_count", 32'(waits), perr ? 32'd1 : 32'(ws));
                    chk("final_resp", {31'd0, sel_resp(s)}, {31'd0, perr});
                    if (perr) chk("err2_rdata", sel_rd(s), 32'd0);
                    else if (!pend.wr) begin
                        last_rd = sel_rd(s);
                        chk("rdata", last_rd, read_m(s, pend.addr));
                    end
                end
            end else if (pk == 1) begin
                chk("idle_okay", {30'd0, rdy, sel_resp(s)}, 32'd2);
            end
            @(posedge hclk);
            #1;
            if (rdy) begin
                if (pk == 2 && !perr && pend.wr) write_m(s, pend);
                if (q.size() > 0) begin
                    pend = q.pop_front();
                    pk = pend.trans[1] ? 2 : 1;
                    perr = !legal_m(pend.addr, pend.size);
                    waits = 0;
                end else begin
                    pk = 0;
                end
            end
        end
        hsel = 1'b0; htrans = 2'd0;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] old;

        repeat (3) @(posedge hclk);
        #1;
        chk("rst_rdy0", {31'd0, rdy0}, 32'd1);
        chk("rst_resp0", {31'd0, resp0}, 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_rdy3", {31'd0, rdy3}, 32'd1);
        chk("rst_resp3", {31'd0, resp3}, 32'd0);
        chk("rst_rd3", rd3, 32'd0);
        @(negedge hclk);
        hrst_b = 1'b1;
        @(posedge hclk);
        #1;

        // Prefill the low 64 bytes of both instances.
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++)
                push(2'd2, BASE + 32'(4 * w), 1'b1, 3'd2, $urandom);
            run_ops(s == 0 ? 0 : 3);
        end

        push(2'd2, BASE + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        push(2'd3, BASE + 32'h10, 1'b0, 3'd2, 32'h0);
        run_ops(0);
        chk("raw_word", last_rd, 32'hDEADBEEF);

        push(2'd2, BASE + 32'h20, 1'b1, 3'd2, 32'hAABBCCDD);
        push(2'd2, BASE + 32'h21, 1'b1, 3'd0, 32'h0000_1100);
        push(2'd2, BASE + 32'h22, 1'b1, 3'd0, 32'h0022_0000);
        push(2'd2, BASE + 32'h20, 1'b0, 3'd2, 32'h0);
        run_ops(0);
        chk("byte_merge", last_rd, 32'hAA2211DD);

        push(2'd2, BASE + 32'h24, 1'b0, 3'd2, 32'h0);
        run_ops(3);

        old = read_m(0, BASE);
        push(2'd2, 32'h3000_0000, 1'b0, 3'd2, 32'h0);
        push(2'd2, BASE + 32'h1, 1'b1, 3'd1, 32'h5555_5555);
        push(2'd2, BASE, 1'b0, 3'd2, 32'h0);
        run_ops(0);
        chk("err_no_write", last_rd, old);
        push(2'd2, BASE + 32'h1000, 1'b1, 3'd2, 32'h1);
        push(2'd2, BASE + 32'h3, 1'b0, 3'd3, 32'h0);
        push(2'd2, BASE + 32'hFFC, 1'b1, 3'd2, 32'h1234_5678);
        push(2'd2, BASE + 32'hFFC, 1'b0, 3'd2, 32'h0);
        run_ops(3);
        chk("top_word", last_rd, 32'h1234_5678);

        push(2'd2, BASE + 32'h8, 1'b1, 3'd1, 32'hBEEF_0000 | 32'h0000_C0DE);
        push(2'd0, BASE + 32'h8, 1'b1, 3'd2, 32'hFFFF_FFFF);
        push(2'd1, BASE + 32'h8, 1'b1, 3'd2, 32'hFFFF_FFFF);
        push(2'd2, BASE + 32'h8, 1'b0, 3'd2, 32'h0);
        run_ops(0);
        run_ops(3);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 150; i++) begin
                sz = 3'($urandom_range(0, 3));
                case ($urandom_range(0, 9))
                    0: a = BASE + 32'h1000 + 32'($urandom_range(0, 7));
                    1: a = BASE - 32'($urandom_range(1, 8));
                    default: a = BASE + 32'($urandom_range(0, 63));
                endcase
                push(2'($urandom_range(0, 3)), a, 1'($urandom), sz, $urandom);
            end
            run_ops(s == 0 ? 0 : 3);
        end

        // Reset in the middle of a waited write must not commit it.
        old = read_m(3, BASE + 32'h4);
        tsel = 3;
        hsel = 1'b1; htrans = 2'd2; haddr = BASE + 32'h4;
        hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk);
        #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = ~old;
        @(posedge hclk);
        #1;
        chk("in_wait", {31'd0, rdy3}, 32'd0);
        hrst_b = 1'b0;
        #1;
        chk("arst_rdy", {31'd0, rdy3}, 32'd1);
        chk("arst_resp", {31'd0, resp3}, 32'd0);
        chk("arst_rd", rd3, 32'd0);
        @(negedge hclk);
        @(negedge hclk);
        hrst_b = 1'b1;
        @(posedge hclk);
        #1;
        push(2'd2, BASE + 32'h4, 1'b0, 3'd2, 32'h0);
        run_ops(3);
        chk("rst_no_write", last_rd, old);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
